reg_read_stage: RTL and testbench

Decode/register-read pipeline stage between instruction fetch and execute. Accepts one fetched 32-bit ARM instruction per cycle over a valid/ready handshake and decodes Rn/Rm/Rd. It drives the read ports of the structural register file (A1, A2, R15) and registers the operands into an output pipeline register for execute. A per-register scoreboard stalls RAW and WAW hazards until the writeback port (WE3/A3/WD3) retires the producing instruction. Same-cycle writeback data is bypassed.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/reg_scoreboard.sv | 46 ++++
 rtl/reg_read_stage.sv | 103 ++++++++++
 tb/tb_reg_read_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared ARM decode constants and instruction field extraction for the pipeline front end.
package cpu_pkg;

  localparam int REG_AW    = 4;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 1 << REG_AW;
  localparam int PC_OFFSET = 8;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  // TST/TEQ/CMP/CMN occupy cmd 10xx and only update flags
  localparam logic [3:0] CMP_MASK  = 4'b1100;
  localparam logic [3:0] CMP_MATCH = 4'b1000;

  localparam int OP_LSB  = 26;
  localparam int I_BIT   = 25;
  localparam int CMD_LSB = 21;
  localparam int L_BIT   = 20;
  localparam int RN_LSB  = 16;
  localparam int RD_LSB  = 12;
  localparam int RM_LSB  = 0;

  typedef struct packed {
    logic [1:0]        op;
    logic              i;
    logic [3:0]        cmd;
    logic              l;
    logic [REG_AW-1:0] rn;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rm;
  } instr_fields_t;

  function automatic instr_fields_t decode_instr(input logic [XLEN-1:0] instr);
    instr_fields_t f;
    f.op  = instr[OP_LSB +: 2];
    f.i   = instr[I_BIT];
    f.cmd = instr[CMD_LSB +: 4];
    f.l   = instr[L_BIT];
    f.rn  = instr[RN_LSB +: REG_AW];
    f.rd  = instr[RD_LSB +: REG_AW];
    f.rm  = instr[RM_LSB +: REG_AW];
    return f;
  endfunction

  function automatic logic writes_dest(input instr_fields_t f);
    logic w;
    w = 1'b0;
    if (f.op == OP_DP)       w = ((f.cmd & CMP_MASK) != CMP_MATCH);
    else if (f.op == OP_MEM) w = f.l;
    return w;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on issue, cleared by writeback or by flushing the held instruction.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [REG_AW-1:0]   set_addr,
  input  logic                clr_en,
  input  logic [REG_AW-1:0]   clr_addr,
  input  logic                clr2_en,
  input  logic [REG_AW-1:0]   clr2_addr,
  input  logic [REG_AW-1:0]   q1_addr,
  input  logic [REG_AW-1:0]   q2_addr,
  input  logic [REG_AW-1:0]   q3_addr,
  output logic                q1_busy,
  output logic                q2_busy,
  output logic                q3_busy,
  output logic [NUM_REGS-1:0] busy_o
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    // NOTE: start from the current value so every path assigns busy_nxt and no latch is inferred.
    busy_nxt = busy;
    if (clr_en)  busy_nxt[clr_addr]  = 1'b0;
    if (clr2_en) busy_nxt[clr2_addr] = 1'b0;
    if (set_en)  busy_nxt[set_addr]  = 1'b1;
    busy_nxt[NUM_REGS-1] = 1'b0;
  end

  // NOTE: these are plain flops, not a RAM, so they are reset; a stale busy bit would stall forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // A register being written back this cycle is already free for the reader.
  assign q1_busy = busy[q1_addr] && !(clr_en && clr_addr == q1_addr);
  assign q2_busy = busy[q2_addr] && !(clr_en && clr_addr == q2_addr);
  assign q3_busy = busy[q3_addr] && !(clr_en && clr_addr == q3_addr);
  assign busy_o  = busy;

endmodule

// File: rtl/reg_read_stage.sv
// Decode/register-read stage: drives register file reads, stalls on RAW/WAW hazards,
// bypasses same-cycle writeback and registers operands for execute.
module reg_read_stage
  import cpu_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [M-1:0] instr_i,
  input  logic [M-1:0] pc_i,
  output logic [N-1:0] A1,
  output logic [N-1:0] A2,
  output logic [M-1:0] R15,
  input  logic [M-1:0] RD1,
  input  logic [M-1:0] RD2,
  input  logic         wb_we,
  input  logic [N-1:0] wb_addr,
  input  logic [M-1:0] wb_data,
  input  logic         flush_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [M-1:0] instr_o,
  output logic [M-1:0] pc_o,
  output logic [M-1:0] rd1_o,
  output logic [M-1:0] rd2_o,
  output logic [N-1:0] dest_o,
  output logic         dest_we_o
);

  instr_fields_t       f;
  logic                writes;
  logic                use_a2;
  logic                a1_busy, a2_busy, dest_busy;
  logic                hazard, advance, issue;
  logic [M-1:0]        rd1_byp, rd2_byp;
  logic [NUM_REGS-1:0] busy;

  assign f      = decode_instr(instr_i);
  assign writes = writes_dest(f);
  // The immediate form of a data-processing op has no Rm operand.
  assign use_a2 = !(f.op == OP_DP && f.i);

  assign A1  = f.rn;
  assign A2  = (f.op == OP_MEM && !f.l) ? f.rd : f.rm;
  assign R15 = pc_i + M'(PC_OFFSET);

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (reset),
    .set_en    (issue && writes && f.rd != '1),
    .set_addr  (f.rd),
    .clr_en    (wb_we),
    .clr_addr  (wb_addr),
    .clr2_en   (flush_i && valid_o && dest_we_o),
    .clr2_addr (dest_o),
    .q1_addr   (A1),
    .q2_addr   (A2),
    .q3_addr   (f.rd),
    .q1_busy   (a1_busy),
    .q2_busy   (a2_busy),
    .q3_busy   (dest_busy),
    .busy_o    (busy)
  );

  assign hazard  = valid_i && (a1_busy || (use_a2 && a2_busy) || (writes && dest_busy));
  assign advance = !valid_o || ready_i;
  assign ready_o = reset && advance && !hazard && !flush_i;
  assign issue   = valid_i && ready_o;

  // R15 reads come from the register file's pc+8 input and are never bypassed.
  assign rd1_byp = (wb_we && wb_addr == A1 && A1 != '1) ? wb_data : RD1;
  assign rd2_byp = (wb_we && wb_addr == A2 && A2 != '1) ? wb_data : RD2;

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_o   <= 1'b0;
      instr_o   <= '0;
      pc_o      <= '0;
      rd1_o     <= '0;
      rd2_o     <= '0;
      dest_o    <= '0;
      dest_we_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (issue) begin
      valid_o   <= 1'b1;
      instr_o   <= instr_i;
      pc_o      <= pc_i;
      rd1_o     <= rd1_byp;
      rd2_o     <= rd2_byp;
      dest_o    <= f.rd;
      dest_we_o <= writes;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage.sv
// Scenario bench for reg_read_stage: a register file model feeds RD1/RD2 and a queue of
// expected output records is checked each time execute takes an instruction.
module tb_reg_read_stage;

  localparam logic [31:0] I_ADD   = 32'hE0821003; // ADD R1,R2,R3
  localparam logic [31:0] I_SUB   = 32'hE2414001; // SUB R4,R1,#1
  localparam logic [31:0] I_LDR   = 32'hE5915000; // LDR R5,[R1]
  localparam logic [31:0] I_STR   = 32'hE5825000; // STR R5,[R2]
  localparam logic [31:0] I_CMP   = 32'hE1510002; // CMP R1,R2
  localparam logic [31:0] I_ADD0  = 32'hE0800000; // ADD R0,R0,R0
  localparam logic [31:0] I_SUB6  = 32'hE2456001; // SUB R6,R5,#1
  localparam logic [31:0] I_MOVPC = 32'hE1A0F000; // MOV PC,R0
  localparam logic [31:0] I_ADDPC = 32'hE08F1002; // ADD R1,PC,R2

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  dest;
    logic        we;
  } exp_t;

  logic        clk, reset;
  logic        valid_i, ready_o, flush_i, valid_o, ready_i;
  logic [31:0] instr_i, pc_i, R15, RD1, RD2, wb_data;
  logic [31:0] instr_o, pc_o, rd1_o, rd2_o;
  logic [3:0]  A1, A2, wb_addr, dest_o;
  logic        wb_we, dest_we_o;

  logic [31:0] regs [16];
  exp_t        exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  reg_read_stage #(.N(4), .M(32)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .A1(A1), .A2(A2), .R15(R15),
    .RD1(RD1), .RD2(RD2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .pc_o(pc_o), .rd1_o(rd1_o), .rd2_o(rd2_o),
    .dest_o(dest_o), .dest_we_o(dest_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Structural register file: R15 reads return the pc+8 input.
  assign RD1 = (A1 == 4'hF) ? R15 : regs[A1];
  assign RD2 = (A2 == 4'hF) ? R15 : regs[A2];
  always @(posedge clk) if (wb_we && wb_addr != 4'hF) regs[wb_addr] <= wb_data;

  initial begin
    #100000;
    $display("FAIL watchdog sim time expired");
    $fatal(1, "watchdog");
  end

  function automatic void push_exp(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [3:0] d, input logic we);
    exp_t e;
    e.instr = ins; e.pc = pc; e.rd1 = r1; e.rd2 = r2; e.dest = d; e.we = we;
    exp_q.push_back(e);
  endfunction

  // Score whatever execute takes at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (valid_o && ready_i && !flush_i) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected instr_o got %h required none", instr_o);
      end else begin
        e = exp_q.pop_front();
        if (instr_o !== e.instr || pc_o !== e.pc || rd1_o !== e.rd1 || rd2_o !== e.rd2 ||
            dest_o !== e.dest || dest_we_o !== e.we) begin
          n_fail++;
          $display("FAIL out_record got instr=%h pc=%h rd1=%h rd2=%h dest=%0d we=%b required instr=%h pc=%h rd1=%h rd2=%h dest=%0d we=%b",
                   instr_o, pc_o, rd1_o, rd2_o, dest_o, dest_we_o,
                   e.instr, e.pc, e.rd1, e.rd2, e.dest, e.we);
        end
      end
    end else if (flush_i && valid_o && exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    valid_i = 1'b1; instr_i = ins; pc_i = pc;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; valid_i = 1'b0; flush_i = 1'b0; wb_we = 1'b0; ready_i = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; valid_i = 1'b1; instr_i = I_ADD; pc_i = 32'h100;
    ready_i = 1'b1; flush_i = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) begin @(posedge clk); #1; end
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid_o got %b required 0", valid_o); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_ready_o got %b required 0", ready_o); end
    n_tests++; if (dut.busy !== 16'h0) begin n_fail++; $display("FAIL rst_busy got %h required 0000", dut.busy); end
    n_tests++; if ({instr_o, pc_o, rd1_o, rd2_o, dest_o, dest_we_o} !== '0) begin
      n_fail++; $display("FAIL rst_outputs got instr=%h dest=%0d we=%b required zero", instr_o, dest_o, dest_we_o); end
    reset = 1'b1;
    #1;
    n_tests++; if (A1 !== 4'd2) begin n_fail++; $display("FAIL add_a1 got %0d required 2", A1); end
    n_tests++; if (A2 !== 4'd3) begin n_fail++; $display("FAIL add_a2 got %0d required 3", A2); end
    n_tests++; if (R15 !== 32'h108) begin n_fail++; $display("FAIL add_r15 got %h required 00000108", R15); end
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL add_ready got %b required 1", ready_o); end
    push_exp(I_ADD, 32'h100, regs[2], regs[3], 4'd1, 1'b1);
    tick();
    valid_i = 1'b0;
    n_tests++; if (valid_o !== 1'b1 || dest_o !== 4'd1 || dest_we_o !== 1'b1) begin
      n_fail++; $display("FAIL add_latency got valid=%b dest=%0d we=%b required 1/1/1", valid_o, dest_o, dest_we_o); end
    tick();
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL add_drain got %b required 0", valid_o); end
  endtask

  task automatic test_raw();
    do_reset();
    present(I_ADD, 32'h200);
    push_exp(I_ADD, 32'h200, regs[2], regs[3], 4'd1, 1'b1);
    tick();
    present(I_SUB, 32'h204);
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall0 got %b required 0", ready_o); end
    tick();
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL raw_stall1 got %b required 0", ready_o); end
    wb_we = 1'b1; wb_addr = 4'd1; wb_data = 32'h55;
    #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL raw_wb_accept got %b required 1", ready_o); end
    push_exp(I_SUB, 32'h204, 32'h55, 32'h55, 4'd4, 1'b1);
    tick();
    wb_we = 1'b0; valid_i = 1'b0;
    n_tests++; if (rd1_o !== 32'h55) begin n_fail++; $display("FAIL raw_bypass got %h required 00000055", rd1_o); end
    tick();
  endtask

  task automatic test_load_store();
    do_reset();
    present(I_LDR, 32'h300);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL ldr_ready got %b required 1", ready_o); end
    push_exp(I_LDR, 32'h300, regs[1], regs[0], 4'd5, 1'b1);
    tick();
    present(I_STR, 32'h304);
    n_tests++; if (A2 !== 4'd5) begin n_fail++; $display("FAIL str_a2 got %0d required 5", A2); end
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL str_wait got %b required 0", ready_o); end
    tick();
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL str_wait2 got %b required 0", ready_o); end
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = 32'h77;
    #1;
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL str_accept got %b required 1", ready_o); end
    push_exp(I_STR, 32'h304, regs[2], 32'h77, 4'd5, 1'b0);
    tick();
    wb_we = 1'b0; valid_i = 1'b0;
    n_tests++; if (dest_we_o !== 1'b0) begin n_fail++; $display("FAIL str_no_write got %b required 0", dest_we_o); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    present(I_CMP, 32'h400);
    push_exp(I_CMP, 32'h400, regs[1], regs[2], 4'd0, 1'b0);
    tick();
    n_tests++; if (dut.busy !== 16'h0) begin n_fail++; $display("FAIL cmp_busy got %h required 0000", dut.busy); end
    present(I_ADD0, 32'h404);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL cmp_no_stall got %b required 1", ready_o); end
    push_exp(I_ADD0, 32'h404, regs[0], regs[0], 4'd0, 1'b1);
    tick();
    valid_i = 1'b0;
    n_tests++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b required 1", valid_o); end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    ready_i = 1'b0;
    present(I_LDR, 32'h500);
    push_exp(I_LDR, 32'h500, regs[1], regs[0], 4'd5, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
    n_tests++; if (valid_o !== 1'b1 || instr_o !== I_LDR) begin
      n_fail++; $display("FAIL flush_hold got valid=%b instr=%h required 1/%h", valid_o, instr_o, I_LDR); end
    n_tests++; if (dut.busy[5] !== 1'b1) begin n_fail++; $display("FAIL flush_busy_set got %b required 1", dut.busy[5]); end
    flush_i = 1'b1;
    #1;
    n_tests++; if (ready_o !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b required 0", ready_o); end
    tick();
    flush_i = 1'b0;
    n_tests++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b required 0", valid_o); end
    n_tests++; if (dut.busy[5] !== 1'b0) begin n_fail++; $display("FAIL flush_busy_clr got %b required 0", dut.busy[5]); end
    ready_i = 1'b1;
    present(I_SUB6, 32'h504);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL flush_next_issue got %b required 1", ready_o); end
    push_exp(I_SUB6, 32'h504, regs[5], regs[1], 4'd6, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_r15();
    do_reset();
    present(I_MOVPC, 32'h600);
    push_exp(I_MOVPC, 32'h600, regs[0], regs[0], 4'd15, 1'b1);
    tick();
    n_tests++; if (dut.busy !== 16'h0) begin n_fail++; $display("FAIL r15_not_tracked got %h required 0000", dut.busy); end
    present(I_ADDPC, 32'h604);
    n_tests++; if (ready_o !== 1'b1) begin n_fail++; $display("FAIL r15_no_stall got %b required 1", ready_o); end
    n_tests++; if (R15 !== 32'h60C) begin n_fail++; $display("FAIL r15_value got %h required 0000060c", R15); end
    push_exp(I_ADDPC, 32'h604, 32'h60C, regs[2], 4'd1, 1'b1);
    tick();
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hA000_0000 | 32'(i);
    test_reset();
    test_raw();
    test_load_store();
    test_back_to_back();
    test_flush();
    test_r15();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL queue_drained got %0d pending required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
